cache_wb_system: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate data cache. It sits between the RISC-V core's load/store port and an external word-wide memory with a ready handshake. It generalises the fixed 8-line, write-through cache to configurable index and line size, and adds per-line dirty bits, burst write-back of victims, and hit/miss statistics counters. The core sees a single combinational stall signal.

---
 rtl/cache_wb_system.sv | 147 ++++++++++++++
 tb/tb_cache_wb_system.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_wb_system.sv
// cache_wb_system: direct-mapped, write-back, write-allocate data cache sitting
// between the core load/store port and a word-wide memory with a ready handshake.
// Misses evict a dirty victim by burst write-back, refill the line, then replay.
module cache_wb_system #(
    parameter int ADDR_W      = 32,
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] byte_address,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    input  logic              mem_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int TAG_W      = ADDR_W - 2 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES      = 2 ** INDEX_BITS;
    localparam int LINE_WORDS = 2 ** OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, ALLOC} state_t;

    state_t                 state;
    logic [OFFSET_BITS-1:0] cnt;
    logic                   replay;
    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [31:0]            data_mem [LINES*LINE_WORDS];

    logic [ADDR_W-3:0]      word_addr;
    logic [OFFSET_BITS-1:0] offset;
    logic [INDEX_BITS-1:0]  index;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   access;
    logic                   last_beat;
    logic                   unused_byte_bits;

    assign word_addr        = byte_address[ADDR_W-1:2];
    assign offset           = word_addr[OFFSET_BITS-1:0];
    assign index            = word_addr[OFFSET_BITS +: INDEX_BITS];
    assign tag              = word_addr[ADDR_W-3 -: TAG_W];
    assign unused_byte_bits = ^byte_address[1:0];

    assign access    = re | we;
    assign hit       = valid[index] & (tag_mem[index] == tag);
    assign last_beat = (cnt == {OFFSET_BITS{1'b1}});
    assign rd        = data_mem[{index, offset}];
    assign mem_wd    = data_mem[{index, cnt}];
    assign stall     = (state == IDLE) ? (access & ~hit) : 1'b1;

    // Beat address: victim tag while writing back, requested tag while refilling.
    always_comb begin
        // NOTE: default first so every path assigns mem_addr and no latch is inferred.
        mem_addr = {tag, index, cnt};
        if (state == WRITEBACK)
            mem_addr = {tag_mem[index], index, cnt};
    end

    // Controller FSM: line state, beat counter, memory request and statistics.
    always_ff @(posedge clk) begin
        // NOTE: all state updates are non-blocking so every read sees pre-edge values.
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            replay     <= 1'b0;
            valid      <= '0;
            dirty      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    replay <= 1'b0;
                    if (access) begin
                        if (hit) begin
                            if (!replay && hit_count != 32'hFFFF_FFFF)
                                hit_count <= hit_count + 32'd1;
                            if (we)
                                dirty[index] <= 1'b1;
                        end else begin
                            if (miss_count != 32'hFFFF_FFFF)
                                miss_count <= miss_count + 32'd1;
                            cnt     <= '0;
                            mem_req <= 1'b1;
                            if (valid[index] && dirty[index]) begin
                                state  <= WRITEBACK;
                                mem_we <= 1'b1;
                            end else begin
                                state  <= REFILL;
                                mem_we <= 1'b0;
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state  <= REFILL;
                            mem_we <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state   <= ALLOC;
                            mem_req <= 1'b0;
                        end
                    end
                end
                ALLOC: begin
                    valid[index] <= 1'b1;
                    dirty[index] <= 1'b0;
                    replay       <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: store hits, refill beats and tag install.
    always_ff @(posedge clk) begin
        // NOTE: the arrays carry no reset; valid/dirty alone decide whether contents count.
        if (state == IDLE && we && hit)
            data_mem[{index, offset}] <= wd;
        if (state == REFILL && mem_ready)
            data_mem[{index, cnt}] <= mem_rd;
        if (state == ALLOC)
            tag_mem[index] <= tag;
    end
endmodule

// File: tb/tb_cache_wb_system.sv
// tb_cache_wb_system: directed checks of the write-back cache against a small
// word memory model; expected values are hand-computed per access.
module tb_cache_wb_system;
    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wd;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic        re;
    logic [31:0] byte_address;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic [31:0] ext_mem [1024];
    logic        slow = 1'b0;
    logic [1:0]  slow_cnt = 2'd0;

    beat_t       beats [$];
    int          hold_err;
    int          errors = 0;
    int          checks = 0;
    int          stalls;
    logic [31:0] rdv;
    logic [31:0] exp_wb [4];

    cache_wb_system dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .re           (re),
        .byte_address (byte_address),
        .wd           (wd),
        .rd           (rd),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .mem_ready    (mem_ready),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    // Memory model: reads are combinational, slow mode completes every 3rd cycle.
    assign mem_rd    = ext_mem[mem_addr[9:0]];
    assign mem_ready = slow ? (slow_cnt == 2'd2) : 1'b1;

    always @(posedge clk) begin
        if (slow && mem_req)
            slow_cnt <= (slow_cnt == 2'd2) ? 2'd0 : slow_cnt + 2'd1;
        else
            slow_cnt <= 2'd0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One core access held until stall drops; logs beats and captures write-backs.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int n_stall, output logic [31:0] rd_seen);
        int          budget;
        logic        prev_req;
        logic        prev_ready;
        logic [29:0] prev_addr;
        beats.delete();
        hold_err   = 0;
        n_stall    = 0;
        rd_seen    = 'x;
        prev_req   = 1'b0;
        prev_ready = 1'b1;
        prev_addr  = '0;
        budget     = 200;
        @(negedge clk);
        re = r; we = w; byte_address = a; wd = d;
        forever begin
            #1;
            if (!stall) begin
                rd_seen = rd;
                break;
            end
            n_stall++;
            if (mem_req && prev_req && !prev_ready && mem_addr != prev_addr)
                hold_err++;
            if (mem_req && mem_ready) begin
                beats.push_back('{mem_we, mem_addr, mem_wd});
                if (mem_we)
                    ext_mem[mem_addr[9:0]] = mem_wd;
            end
            prev_req   = mem_req;
            prev_ready = mem_ready;
            prev_addr  = mem_addr;
            budget--;
            if (budget == 0) begin
                check("access_timeout_stall", {31'b0, stall}, 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        re = 1'b0; we = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++)
            ext_mem[i] = 32'h1000_0000 + i;
        for (int i = 0; i < 4; i++)
            ext_mem[16 + i] = 32'hA0 + i;
        exp_wb[0] = 32'hA0; exp_wb[1] = 32'hDEADBEEF; exp_wb[2] = 32'hA2; exp_wb[3] = 32'hA3;

        reset = 1'b1; re = 1'b0; we = 1'b0; byte_address = '0; wd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_mem_req", {31'b0, mem_req}, 0);
        check("rst_mem_we", {31'b0, mem_we}, 0);
        check("rst_hit", hit_count, 0);
        check("rst_miss", miss_count, 0);
        reset = 1'b0;

        // Cold load miss on index 4, tag 0.
        access(1, 0, 32'h40, 0, stalls, rdv);
        check("cold_stalls", 32'(stalls), 6);
        check("cold_beats", 32'(beats.size()), 4);
        foreach (beats[i]) begin
            check("cold_beat_we", {31'b0, beats[i].we}, 0);
            check("cold_beat_addr", {2'b0, beats[i].addr}, 32'h10 + i);
        end
        check("cold_rd", rdv, 32'hA0);
        check("cold_miss", miss_count, 1);
        check("cold_hit", hit_count, 0);

        // Read hit on the last word of the line.
        access(1, 0, 32'h4C, 0, stalls, rdv);
        check("hit_stalls", 32'(stalls), 0);
        check("hit_rd", rdv, 32'hA3);
        check("hit_count1", hit_count, 1);

        // Store hit, then a conflicting miss forces a dirty eviction.
        access(0, 1, 32'h44, 32'hDEADBEEF, stalls, rdv);
        check("store_stalls", 32'(stalls), 0);
        check("store_hit", hit_count, 2);
        access(1, 0, 32'h240, 0, stalls, rdv);
        check("evict_stalls", 32'(stalls), 10);
        check("evict_beats", 32'(beats.size()), 8);
        foreach (beats[i]) begin
            if (i < 4) begin
                check("wb_we", {31'b0, beats[i].we}, 1);
                check("wb_addr", {2'b0, beats[i].addr}, 32'h10 + i);
                check("wb_data", beats[i].wd, exp_wb[i]);
            end else begin
                check("refill_we", {31'b0, beats[i].we}, 0);
                check("refill_addr", {2'b0, beats[i].addr}, 32'h90 + i - 4);
            end
        end
        check("evict_rd", rdv, 32'h1000_0090);
        check("evict_miss", miss_count, 2);
        check("evict_hit", hit_count, 2);

        // Slow memory: one beat every third cycle.
        slow = 1'b1;
        access(1, 0, 32'h80, 0, stalls, rdv);
        slow = 1'b0;
        check("slow_stalls", 32'(stalls), 14);
        check("slow_beats", 32'(beats.size()), 4);
        check("slow_addr_hold", 32'(hold_err), 0);
        check("slow_rd", rdv, 32'h1000_0020);
        check("slow_miss", miss_count, 3);

        // Reset asserted during refill beat 2.
        @(negedge clk);
        re = 1'b1; byte_address = 32'hC0;
        #1 check("mr_detect_stall", {31'b0, stall}, 1);
        repeat (3) @(negedge clk);
        #1;
        check("mr_beat2_addr", {2'b0, mem_addr}, 32'h32);
        check("mr_beat2_req", {31'b0, mem_req}, 1);
        reset = 1'b1; re = 1'b0;
        @(negedge clk); #1;
        check("mr_mem_req", {31'b0, mem_req}, 0);
        check("mr_mem_we", {31'b0, mem_we}, 0);
        check("mr_stall", {31'b0, stall}, 0);
        check("mr_hit", hit_count, 0);
        check("mr_miss", miss_count, 0);
        reset = 1'b0;
        access(1, 0, 32'hC0, 0, stalls, rdv);
        check("mr_reaccess_stalls", 32'(stalls), 6);
        check("mr_reaccess_rd", rdv, 32'h1000_0030);
        check("mr_reaccess_miss", miss_count, 1);
        access(1, 0, 32'h240, 0, stalls, rdv);
        check("mr_valid_cleared_stalls", 32'(stalls), 6);
        check("mr_valid_cleared_rd", rdv, 32'h1000_0090);

        // Bring back the written-back line, then a simultaneous read/write hit.
        access(1, 0, 32'h40, 0, stalls, rdv);
        check("rw_fill_stalls", 32'(stalls), 6);
        check("rw_fill_rd", rdv, 32'hA0);
        check("rw_fill_miss", miss_count, 3);
        access(1, 1, 32'h48, 32'h5, stalls, rdv);
        check("rw_stalls", 32'(stalls), 0);
        check("rw_old_rd", rdv, 32'hA2);
        check("rw_hit", hit_count, 1);
        check("rw_miss", miss_count, 3);
        access(1, 0, 32'h48, 0, stalls, rdv);
        check("rw_new_rd", rdv, 32'h5);
        check("rw_hit2", hit_count, 2);
        access(1, 0, 32'h44, 0, stalls, rdv);
        check("wb_roundtrip_rd", rdv, 32'hDEADBEEF);
        check("wb_roundtrip_hit", hit_count, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
